// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 datapath width, PC type and branch funct3 encodings
package rv32_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] pc_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition from funct3, ALU zero flag and SLT bit
module branch_cond_eval
   import rv32_pkg::*;
(
   input  logic [2:0] func3_i,
   input  logic       zero_i,
   input  logic       alu_lsb_i,
   output logic       cond_o
);

   // Signed and unsigned compares share a bit: the ALU already picked SLT or SLTU.
   always_comb begin
      cond_o = 1'b0;
      case (func3_i)
         F3_BEQ:  cond_o = zero_i;
         F3_BNE:  cond_o = ~zero_i;
         F3_BLT:  cond_o = alu_lsb_i;
         F3_BGE:  cond_o = ~alu_lsb_i;
         F3_BLTU: cond_o = alu_lsb_i;
         F3_BGEU: cond_o = ~alu_lsb_i;
         default: cond_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_jump_ctrl.sv
// rtl/branch_jump_ctrl.sv - EX-stage branch/jump resolution with registered redirect; optional BRANCH_JUMP_JALR_EN
module branch_jump_ctrl #(
   parameter int          XLEN    = rv32_pkg::XLEN,
   parameter int unsigned PC_STEP = 4
) (
   input  logic            CLK,
   input  logic            RESETN,
   input  logic            BRANCH,
   input  logic            JUMP,
`ifdef BRANCH_JUMP_JALR_EN
   input  logic            JALR,
`endif
   input  logic            ZERO,
   input  logic [XLEN-1:0] ALU_OUT,
   input  logic [2:0]      Func3,
   input  logic [XLEN-1:0] PC,
   input  logic [XLEN-1:0] IMM_VALUE,
   output logic [XLEN-1:0] NEXT_PC,
   output logic            MUX_SELECT,
   output logic            FLUSH
);

   import rv32_pkg::*;

   logic            cond;
   logic            take_d;
   logic            take_q;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] next_pc_d;
   logic [XLEN-1:0] next_pc_q;

   branch_cond_eval u_cond (
      .func3_i   (Func3),
      .zero_i    (ZERO),
      .alu_lsb_i (ALU_OUT[0]),
      .cond_o    (cond)
   );

`ifdef BRANCH_JUMP_JALR_EN
   // JALR target comes from the ALU (rs1+imm) with bit 0 cleared.
   assign target = (JUMP && JALR) ? {ALU_OUT[XLEN-1:1], 1'b0} : PC + IMM_VALUE;
`else
   logic unused_alu_upper;
   assign unused_alu_upper = ^ALU_OUT[XLEN-1:1];
   assign target = PC + IMM_VALUE;
`endif

   assign seq_pc    = PC + XLEN'(PC_STEP);
   assign take_d    = (BRANCH & cond) | JUMP;
   assign next_pc_d = take_d ? target : seq_pc;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         take_q    <= 1'b0;
         next_pc_q <= '0;
      end else begin
         take_q    <= take_d;
         next_pc_q <= next_pc_d;
      end
   end

   assign NEXT_PC    = next_pc_q;
   assign MUX_SELECT = take_q;
   assign FLUSH      = take_q;

endmodule

// File: tb/tb_branch_jump_ctrl.sv
// tb/tb_branch_jump_ctrl.sv - self-checking bench for branch_jump_ctrl with directed tables and random reference model
module tb_branch_jump_ctrl;

   logic        CLK = 1'b0;
   logic        RESETN;
   logic        BRANCH;
   logic        JUMP;
   logic        ZERO;
   logic [31:0] ALU_OUT;
   logic [2:0]  Func3;
   logic [31:0] PC;
   logic [31:0] IMM_VALUE;
   logic [31:0] NEXT_PC;
   logic        MUX_SELECT;
   logic        FLUSH;
`ifdef BRANCH_JUMP_JALR_EN
   logic        JALR = 1'b0;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      string       nm;
      logic        b;
      logic        j;
      logic [2:0]  f3;
      logic        z;
      logic [31:0] alu;
      logic [31:0] exp_pc;
      logic        exp_t;
   } vec_t;

   branch_jump_ctrl dut (
      .CLK        (CLK),
      .RESETN     (RESETN),
      .BRANCH     (BRANCH),
      .JUMP       (JUMP),
`ifdef BRANCH_JUMP_JALR_EN
      .JALR       (JALR),
`endif
      .ZERO       (ZERO),
      .ALU_OUT    (ALU_OUT),
      .Func3      (Func3),
      .PC         (PC),
      .IMM_VALUE  (IMM_VALUE),
      .NEXT_PC    (NEXT_PC),
      .MUX_SELECT (MUX_SELECT),
      .FLUSH      (FLUSH)
   );

   always #5 CLK = ~CLK;

   // Reference: condition table and modulo-2^32 arithmetic computed with wide integers.
   function automatic logic [33:0] model(input logic b, input logic j, input logic [2:0] f3,
                                         input logic z, input logic [31:0] alu,
                                         input logic [31:0] pc, input logic [31:0] imm);
      bit          cond;
      bit          take;
      longint      sum;
      logic [31:0] npc;
      case (f3)
         3'd0:       cond = (z == 1'b1);
         3'd1:       cond = (z == 1'b0);
         3'd4, 3'd6: cond = (alu % 2 == 1);
         3'd5, 3'd7: cond = (alu % 2 == 0);
         default:    cond = 0;
      endcase
      take = j || (b && cond);
      sum  = take ? (longint'(pc) + longint'(imm)) : (longint'(pc) + 4);
      npc  = 32'(sum % 64'h1_0000_0000);
      return {npc, take, take};
   endfunction

   task automatic drive(input logic b, input logic j, input logic [2:0] f3, input logic z,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm);
      BRANCH = b; JUMP = j; Func3 = f3; ZERO = z; ALU_OUT = alu; PC = pc; IMM_VALUE = imm;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESETN = 1'b0;
      BRANCH = 1'b1; JUMP = 1'b1; Func3 = 3'd0; ZERO = 1'b1;
      ALU_OUT = 32'h1; PC = 32'h4; IMM_VALUE = 32'h8;
      repeat (2) @(posedge CLK);
      #1;
      tests_run++;
      if ({NEXT_PC, MUX_SELECT, FLUSH} !== 34'h0) begin
         tests_failed++;
         $display("FAIL reset_hold: got pc=%h mux=%b flush=%b, want 0/0/0", NEXT_PC, MUX_SELECT, FLUSH);
      end
      @(negedge CLK);
      RESETN = 1'b1;
   endtask

   task automatic test_branches();
      vec_t tbl[$];
      tbl.push_back('{"beq_taken",     1, 0, 3'b000, 1, 32'h0,        32'hC, 1});
      tbl.push_back('{"beq_not",       1, 0, 3'b000, 0, 32'h0,        32'h8, 0});
      tbl.push_back('{"bne_taken",     1, 0, 3'b001, 0, 32'h0,        32'hC, 1});
      tbl.push_back('{"blt_taken",     1, 0, 3'b100, 0, 32'h1,        32'hC, 1});
      tbl.push_back('{"blt_not",       1, 0, 3'b100, 0, 32'h0,        32'h8, 0});
      tbl.push_back('{"blt_upper_ign", 1, 0, 3'b100, 0, 32'hFFFFFFFE, 32'h8, 0});
      tbl.push_back('{"bge_taken",     1, 0, 3'b101, 0, 32'h0,        32'hC, 1});
      tbl.push_back('{"bltu_taken",    1, 0, 3'b110, 0, 32'h1,        32'hC, 1});
      tbl.push_back('{"bgeu_taken",    1, 0, 3'b111, 0, 32'h0,        32'hC, 1});
      tbl.push_back('{"bgeu_not",      1, 0, 3'b111, 0, 32'h1,        32'h8, 0});
      tbl.push_back('{"illegal_010",   1, 0, 3'b010, 1, 32'h1,        32'h8, 0});
      tbl.push_back('{"illegal_011",   1, 0, 3'b011, 1, 32'h0,        32'h8, 0});
      foreach (tbl[i]) begin
         drive(tbl[i].b, tbl[i].j, tbl[i].f3, tbl[i].z, tbl[i].alu, 32'h4, 32'h8);
         tests_run++;
         if ({NEXT_PC, MUX_SELECT, FLUSH} !== {tbl[i].exp_pc, tbl[i].exp_t, tbl[i].exp_t}) begin
            tests_failed++;
            $display("FAIL %s: got pc=%h mux=%b flush=%b, want pc=%h sel=%b",
                     tbl[i].nm, NEXT_PC, MUX_SELECT, FLUSH, tbl[i].exp_pc, tbl[i].exp_t);
         end
      end
   endtask

   task automatic test_jump();
      vec_t tbl[$];
      tbl.push_back('{"jal",           0, 1, 3'b000, 0, 32'h0,        32'hC, 1});
      tbl.push_back('{"jal_over_beq",  1, 1, 3'b000, 0, 32'h0,        32'hC, 1});
      tbl.push_back('{"jal_illegal",   1, 1, 3'b010, 0, 32'hFFFFFFFF, 32'hC, 1});
      tbl.push_back('{"nop",           0, 0, 3'b000, 0, 32'h0,        32'h8, 0});
      tbl.push_back('{"nop_garbage",   0, 0, 3'b001, 0, 32'h1,        32'h8, 0});
      foreach (tbl[i]) begin
         drive(tbl[i].b, tbl[i].j, tbl[i].f3, tbl[i].z, tbl[i].alu, 32'h4, 32'h8);
         tests_run++;
         if ({NEXT_PC, MUX_SELECT, FLUSH} !== {tbl[i].exp_pc, tbl[i].exp_t, tbl[i].exp_t}) begin
            tests_failed++;
            $display("FAIL %s: got pc=%h mux=%b flush=%b, want pc=%h sel=%b",
                     tbl[i].nm, NEXT_PC, MUX_SELECT, FLUSH, tbl[i].exp_pc, tbl[i].exp_t);
         end
      end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b1, 3'b000, 1'b0, 32'h0, 32'hFFFFFFFC, 32'h8);
      tests_run++;
      if ({NEXT_PC, MUX_SELECT, FLUSH} !== {32'h00000004, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL wrap_target: got pc=%h mux=%b flush=%b, want 00000004/1/1", NEXT_PC, MUX_SELECT, FLUSH);
      end
      drive(1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'hFFFFFFFC, 32'h8);
      tests_run++;
      if ({NEXT_PC, MUX_SELECT, FLUSH} !== {32'h00000000, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL wrap_seq: got pc=%h mux=%b flush=%b, want 00000000/0/0", NEXT_PC, MUX_SELECT, FLUSH);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b1, 3'b000, 1'b0, 32'h0, 32'h4, 32'h8);
      tests_run++;
      if ({NEXT_PC, MUX_SELECT, FLUSH} !== {32'hC, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL async_pre: got pc=%h mux=%b flush=%b, want 0000000c/1/1", NEXT_PC, MUX_SELECT, FLUSH);
      end
      #2 RESETN = 1'b0;
      #1;
      tests_run++;
      if ({NEXT_PC, MUX_SELECT, FLUSH} !== 34'h0) begin
         tests_failed++;
         $display("FAIL async_clear: got pc=%h mux=%b flush=%b, want 0/0/0", NEXT_PC, MUX_SELECT, FLUSH);
      end
      @(posedge CLK);
      #1;
      tests_run++;
      if ({NEXT_PC, MUX_SELECT, FLUSH} !== 34'h0) begin
         tests_failed++;
         $display("FAIL async_held: got pc=%h mux=%b flush=%b, want 0/0/0", NEXT_PC, MUX_SELECT, FLUSH);
      end
      @(negedge CLK);
      RESETN = 1'b1;
      @(posedge CLK);
      #1;
      tests_run++;
      if ({NEXT_PC, MUX_SELECT, FLUSH} !== {32'hC, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL async_release: got pc=%h mux=%b flush=%b, want 0000000c/1/1", NEXT_PC, MUX_SELECT, FLUSH);
      end
   endtask

   task automatic test_back_to_back();
      logic [33:0] exp;
      logic        b, j, z;
      logic [2:0]  f3;
      logic [31:0] alu, pc, imm;
      for (int n = 0; n < 300; n++) begin
         b   = 1'($urandom_range(0, 1));
         j   = ($urandom_range(0, 3) == 0);
         z   = 1'($urandom_range(0, 1));
         f3  = 3'($urandom_range(0, 7));
         alu = $urandom;
         pc  = (n % 10 == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
         imm = $urandom;
         exp = model(b, j, f3, z, alu, pc, imm);
         drive(b, j, f3, z, alu, pc, imm);
         tests_run++;
         if ({NEXT_PC, MUX_SELECT, FLUSH} !== exp) begin
            tests_failed++;
            $display("FAIL rand_%0d: got pc=%h mux=%b flush=%b, want pc=%h sel=%b",
                     n, NEXT_PC, MUX_SELECT, FLUSH, exp[33:2], exp[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_branches();
      test_jump();
      test_wrap();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
